// File: rtl/dmem_pkg.sv
// Shared encodings and request payload for the data-memory responder.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [1:0]        size;
    logic              is_unsigned;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables/replicated data, load extract and extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offs,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_sh_c,
  output logic [31:0] rdata_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c     = rword[{offs, 3'b000} +: 8];
    half_c     = offs[1] ? rword[31:16] : rword[15:0];
    be_c       = 4'hF;
    wdata_sh_c = wdata;
    rdata_c    = rword;
    case (size)
      SZ_BYTE: begin
        be_c       = 4'b0001 << offs;
        wdata_sh_c = {4{wdata[7:0]}};
        rdata_c    = is_unsigned ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      end
      SZ_HALF: begin
        be_c       = 4'b0011 << {offs[1], 1'b0};
        wdata_sh_c = {2{wdata[15:0]}};
        rdata_c    = is_unsigned ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable wait states.
// Define DMEM_ERR_CHECK_EN to flag misaligned, illegal-size and out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_e           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  req_t             req_q, req_in_c, req_sel_c;
  logic             handshake_c, commit_c, write_en_c, err_c;
  logic [29:0]      word_addr_c;
  logic [IDX_W-1:0] idx_c;
  logic [1:0]       size_eff_c, offs_c;
  logic [31:0]      rword_c, wdata_sh_c, load_c;
  logic [3:0]       be_c;

  assign handshake_c = req_valid & req_ready;

  always_comb begin
    req_in_c.addr        = req_addr;
    req_in_c.wdata       = req_wdata;
    req_in_c.we          = req_we;
    req_in_c.size        = req_size;
    req_in_c.is_unsigned = req_unsigned;
  end

  // Zero-wait builds commit on the handshake edge, before req_q holds the request.
  assign req_sel_c   = (state == IDLE) ? req_in_c : req_q;
  assign word_addr_c = req_sel_c.addr[31:2];

  always_comb begin
`ifdef DMEM_ERR_CHECK_EN
    err_c = ((req_sel_c.size == SZ_HALF) && req_sel_c.addr[0])
         || ((req_sel_c.size == SZ_WORD) && (req_sel_c.addr[1:0] != 2'b00))
         || (req_sel_c.size == SZ_ILLEGAL)
         || ({2'b00, word_addr_c} >= 32'(DEPTH_WORDS));
    size_eff_c = req_sel_c.size;
    offs_c     = req_sel_c.addr[1:0];
    idx_c      = IDX_W'(word_addr_c);
`else
    err_c      = 1'b0;
    size_eff_c = (req_sel_c.size == SZ_ILLEGAL) ? SZ_WORD : req_sel_c.size;
    case (size_eff_c)
      SZ_BYTE: offs_c = req_sel_c.addr[1:0];
      SZ_HALF: offs_c = {req_sel_c.addr[1], 1'b0};
      default: offs_c = 2'b00;
    endcase
    idx_c = IDX_W'(word_addr_c % 30'(DEPTH_WORDS));
`endif
  end

  assign rword_c = mem[idx_c];

  dmem_lane_align u_lane_align (
    .size        (size_eff_c),
    .offs        (offs_c),
    .is_unsigned (req_sel_c.is_unsigned),
    .wdata       (req_sel_c.wdata),
    .rword       (rword_c),
    .be_c        (be_c),
    .wdata_sh_c  (wdata_sh_c),
    .rdata_c     (load_c)
  );

  // Next-state logic; commit_c marks the single edge that enters RESP.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    commit_c     = 1'b0;
    case (state)
      IDLE: begin
        if (handshake_c) begin
          wait_cnt_nxt = '0;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            commit_c  = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == CNT_LAST) begin
          state_nxt    = RESP;
          commit_c     = 1'b1;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      req_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (handshake_c) req_q <= req_in_c;
      if (commit_c) begin
        rsp_err   <= err_c;
        rsp_rdata <= (req_sel_c.we || err_c) ? 32'h0 : load_c;
      end
    end
  end

  // Reset on the commit edge drops the store; storage itself is never reset.
  assign write_en_c = commit_c & ~rst & ~err_c & req_sel_c.we;

  always_ff @(posedge clk) begin
    if (write_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wdata_sh_c[8*i +: 8];
      end
    end
  end

endmodule
